pep_mmacc_body_buf: RTL and testbench
=====================================

Name: pep_mmacc_body_buf

Overview:
- Per-PBS-slot store for the key-switched LWE body coefficient and its accumulated sequencer correction, inside the PEP mono-mult-accumulate path.
- On a read request for a slot (pid plus parity), it applies mean compensation and correction, mod-switches the result to LWE_COEF_W and streams it to the sample-extract stage.

Parameters:
- TOTAL_PBS_NB, 64, number of pid slots.
- PID_W, $clog2(TOTAL_PBS_NB), pid width.
- MOD_KSK_W, 21, KS body width; MOD_KSK = 2**MOD_KSK_W.
- LWE_COEF_W, 12, output width.
- KS_MAX_ERROR_W, 16, signed correction width.
- LWE_K, 630, correction writes expected per slot.
- N, 2048, polynomial degree, used by centering.
- USE_MEAN_COMP, 0, enables centering.
- KS_KEY_MEAN_FP, 1, key mean as unsigned fixed point.
- KS_KEY_MEAN_FRAC_W, 1, fractional bits of KS_KEY_MEAN_FP. Default value is 0.5.

Ports:
- clk  in  1  clock
- a_rst_n  in  1  asynchronous active-low reset
- reset_cache  in  1  synchronous clear of all slots
- ks_boram_wr_en  in  1  body write strobe
- ks_boram_wr_data  in  MOD_KSK_W  body value
- ks_boram_wr_pid  in  PID_W  slot
- ks_boram_wr_parity  in  1  parity tag of the write
- seq_boram_corr_wr_en  in  1  correction write strobe
- seq_boram_corr_wr_data  in  KS_MAX_ERROR_W  signed correction
- seq_boram_corr_wr_pid  in  PID_W  slot
- boram_rd_pid  in  PID_W  slot to read
- boram_rd_parity  in  1  required parity
- boram_rd_vld  in  1  read request valid
- boram_rd_rdy  out  1  read request accepted
- boram_sxt_data  out  LWE_COEF_W  mod-switched body
- boram_sxt_data_vld  out  1  output valid
- boram_sxt_data_rdy  in  1  output ready

Behaviour:
- Per-slot state:
  - body register, MOD_KSK_W bits;
  - parity bit;
  - body-valid flag;
  - signed correction accumulator, KS_MAX_ERROR_W bits, wrapping;
  - correction counter, 0..LWE_K.
- Reset (a_rst_n low) or reset_cache high:
  - all valid flags, parities, accumulators and counters go to 0;
  - output stage emptied;
  - boram_sxt_data_vld=0 and boram_rd_rdy=0 during reset.
- Body write:
  - Unconditionally stores data and parity and sets valid.
  - A rewrite of a valid slot overwrites both data and parity.
- Correction write:
  - acc += data (sign-extended, wrap); cnt++.
  - Writes arriving when cnt==LWE_K are dropped.
- Slot ready = valid AND stored parity==boram_rd_parity AND cnt==LWE_K.
- boram_rd_rdy = boram_rd_vld AND slot ready AND output stage free (empty, or being consumed this cycle).
  - Any mismatch (wrong parity, missing body, incomplete corrections) stalls the request with no side effect.
- On read accept (vld&rdy), in the next cycle:
  - result is registered into the output stage, so latency = 1 cycle;
  - slot's valid, acc and cnt are cleared.
- Same-cycle collisions on the accepted pid:
  - body write wins: slot stays valid with the new data;
  - correction write is applied after the clear, so cnt=1.
- Arithmetic, all exact, no real numbers:
  - c = USE_MEAN_COMP ? (body − MOD_KSK/(4N)) mod MOD_KSK : body.
  - v = c·2^F − acc·KS_KEY_MEAN_FP, signed, full width, with F=KS_KEY_MEAN_FRAC_W.
  - v is taken mod 2^(MOD_KSK_W+F).
  - Then add 2^(MOD_KSK_W−LWE_COEF_W+F−1) and take bits [MOD_KSK_W+F−1 : MOD_KSK_W−LWE_COEF_W+F].
  - This equals floor(x/2^(MOD_KSK_W−LWE_COEF_W)+0.5) mod 2^LWE_COEF_W, with x the real-valued result.
- Output handshake:
  - Data is held stable while vld=1 and rdy=0.
  - Output stage holds one entry; rd_rdy stays back-pressured until it is freed.

Optional Feature:
- BORAM_ASSERT_EN defined: simulation-only assertions flag:
  - a correction write with cnt==LWE_K;
  - rd_vld with pid ≥ TOTAL_PBS_NB;
  - output data change while vld&!rdy.
- Undefined: no assertion logic; RTL behaviour identical.

Decomposition:
- Shared package (param_tfhe_pkg / pep_common_param_pkg):
  - constants TOTAL_PBS_NB, PID_W, MOD_KSK_W, MOD_KSK, LWE_COEF_W, KS_MAX_ERROR_W, LWE_K, N, USE_MEAN_COMP, KS_KEY_MEAN_FP/FRAC_W;
  - types pid_t, ks_coeff_t, modsw_coeff_t, seq_corr_t (signed).
- One sub-module, pep_mmacc_body_modsw: combinational centering, correction and rounding function.

Test Plan:
- Basic: write pid3 body=0x1FF parity0, LWE_K corrections of 0, read pid3 parity0 → out 0x001 one cycle after accept.
- Parity block: write pid5 parity1 and complete its corrections, read pid5 parity0 → rd_rdy stays 0; then write pid5 parity0 same data → accepted next cycle, out correct.
- Correction: body 0x800, corrections summing to +1024, mean 0.5 → 0x800−0x200=0x600 → out 0x003.
- Negative wrap: body 0, corrections sum +1024 → −512 mod 2^21 → out 0xFFF.
- reset_cache: write pid7 with all corrections, pulse reset_cache, read pid7 → rd_rdy stays 0 until the slot is fully rewritten.
- Backpressure: hold sxt_rdy=0 for 10 cycles with a second read pending → data stable, second rd_rdy=0; release → both outputs delivered in order.

Source files
------------

// File: rtl/pep_mmacc_body_buf_pkg.sv
// pep_mmacc_body_buf_pkg: shared constants and types for the PEP body buffer and its mod-switch stage.
`default_nettype none
package pep_mmacc_body_buf_pkg;
  localparam int TOTAL_PBS_NB       = 64;
  localparam int PID_W              = $clog2(TOTAL_PBS_NB);
  localparam int MOD_KSK_W          = 21;
  localparam int MOD_KSK            = 2 ** MOD_KSK_W;
  localparam int LWE_COEF_W         = 12;
  localparam int KS_MAX_ERROR_W     = 16;
  localparam int LWE_K              = 630;
  localparam int N                  = 2048;
  localparam int USE_MEAN_COMP      = 0;
  localparam int KS_KEY_MEAN_FP     = 1;
  localparam int KS_KEY_MEAN_FRAC_W = 1;

  localparam int CNT_W    = $clog2(LWE_K + 1);
  localparam int VAL_W    = MOD_KSK_W + KS_KEY_MEAN_FRAC_W;
  localparam int RND_LSB  = MOD_KSK_W - LWE_COEF_W + KS_KEY_MEAN_FRAC_W;
  localparam int MEAN_OFS = MOD_KSK / (4 * N);

  typedef logic [PID_W-1:0]                 pid_t;
  typedef logic [MOD_KSK_W-1:0]             ks_coeff_t;
  typedef logic [LWE_COEF_W-1:0]            modsw_coeff_t;
  typedef logic signed [KS_MAX_ERROR_W-1:0] seq_corr_t;
  typedef logic [CNT_W-1:0]                 cnt_t;
endpackage
`default_nettype wire

// File: rtl/pep_mmacc_body_buf_if.sv
// pep_mmacc_body_buf_if: write, correction, read-request and sample-extract stream signals.
`default_nettype none
interface pep_mmacc_body_buf_if;
  import pep_mmacc_body_buf_pkg::*;

  logic         reset_cache;
  logic         ks_boram_wr_en;
  ks_coeff_t    ks_boram_wr_data;
  pid_t         ks_boram_wr_pid;
  logic         ks_boram_wr_parity;
  logic         seq_boram_corr_wr_en;
  seq_corr_t    seq_boram_corr_wr_data;
  pid_t         seq_boram_corr_wr_pid;
  pid_t         boram_rd_pid;
  logic         boram_rd_parity;
  logic         boram_rd_vld;
  logic         boram_rd_rdy;
  modsw_coeff_t boram_sxt_data;
  logic         boram_sxt_data_vld;
  logic         boram_sxt_data_rdy;

  modport slave (
    input  reset_cache,
    input  ks_boram_wr_en, ks_boram_wr_data, ks_boram_wr_pid, ks_boram_wr_parity,
    input  seq_boram_corr_wr_en, seq_boram_corr_wr_data, seq_boram_corr_wr_pid,
    input  boram_rd_pid, boram_rd_parity, boram_rd_vld,
    output boram_rd_rdy,
    output boram_sxt_data, boram_sxt_data_vld,
    input  boram_sxt_data_rdy
  );

  modport master (
    output reset_cache,
    output ks_boram_wr_en, ks_boram_wr_data, ks_boram_wr_pid, ks_boram_wr_parity,
    output seq_boram_corr_wr_en, seq_boram_corr_wr_data, seq_boram_corr_wr_pid,
    output boram_rd_pid, boram_rd_parity, boram_rd_vld,
    input  boram_rd_rdy,
    input  boram_sxt_data, boram_sxt_data_vld,
    output boram_sxt_data_rdy
  );
endinterface
`default_nettype wire

// File: rtl/pep_mmacc_body_modsw.sv
// pep_mmacc_body_modsw: combinational centering, key-mean correction and rounding mod-switch.
`default_nettype none
module pep_mmacc_body_modsw
  import pep_mmacc_body_buf_pkg::*;
(
  input  ks_coeff_t    i_body,
  input  seq_corr_t    i_acc,
  output modsw_coeff_t o_data
);
  ks_coeff_t        w_c;
  logic [VAL_W-1:0] w_c_sh;
  logic [VAL_W-1:0] w_acc_ext;
  logic [VAL_W-1:0] w_corr;
  logic [VAL_W-1:0] w_v;
  logic [VAL_W-1:0] w_rnd;

  generate
    if (USE_MEAN_COMP != 0) begin : g_mean_comp
      assign w_c = i_body - ks_coeff_t'(MEAN_OFS);
    end else begin : g_no_mean_comp
      assign w_c = i_body;
    end
  endgenerate

  // Everything lives in mod 2^VAL_W, so two's-complement truncation is exact.
  assign w_c_sh    = VAL_W'(w_c) << KS_KEY_MEAN_FRAC_W;
  assign w_acc_ext = {{(VAL_W-KS_MAX_ERROR_W){i_acc[KS_MAX_ERROR_W-1]}}, i_acc};
  assign w_corr    = w_acc_ext * VAL_W'(KS_KEY_MEAN_FP);
  assign w_v       = w_c_sh - w_corr;
  assign w_rnd     = w_v + (VAL_W'(1) << (RND_LSB - 1));
  assign o_data    = w_rnd[VAL_W-1:RND_LSB];
endmodule
`default_nettype wire

// File: rtl/pep_mmacc_body_buf.sv
// pep_mmacc_body_buf: per-PBS-slot body/correction store with one-entry mod-switched output stage.
// Optional BORAM_ASSERT_EN adds simulation-only protocol assertions.
`default_nettype none
module pep_mmacc_body_buf
  import pep_mmacc_body_buf_pkg::*;
(
  input  logic                 clk,
  input  logic                 a_rst_n,
  pep_mmacc_body_buf_if.slave  bus
);
  logic         r_vld  [TOTAL_PBS_NB];
  logic         r_par  [TOTAL_PBS_NB];
  ks_coeff_t    r_body [TOTAL_PBS_NB];
  seq_corr_t    r_acc  [TOTAL_PBS_NB];
  cnt_t         r_cnt  [TOTAL_PBS_NB];
  logic         r_out_vld;
  modsw_coeff_t r_out_data;

  logic         w_wr_hit   [TOTAL_PBS_NB];
  logic         w_clr      [TOTAL_PBS_NB];
  logic         w_corr_tk  [TOTAL_PBS_NB];
  logic         w_slot_rdy;
  logic         w_out_free;
  logic         w_accept;
  modsw_coeff_t w_modsw;

  assign w_slot_rdy = r_vld[bus.boram_rd_pid]
                   && (r_par[bus.boram_rd_pid] == bus.boram_rd_parity)
                   && (r_cnt[bus.boram_rd_pid] == cnt_t'(LWE_K));
  assign w_out_free = !r_out_vld || bus.boram_sxt_data_rdy;
  assign w_accept   = a_rst_n && !bus.reset_cache && bus.boram_rd_vld
                   && w_slot_rdy && w_out_free;

  assign bus.boram_rd_rdy       = w_accept;
  assign bus.boram_sxt_data     = r_out_data;
  assign bus.boram_sxt_data_vld = r_out_vld;

  // A correction landing on a slot being cleared counts as the first of the next round.
  always_comb begin
    for (int i = 0; i < TOTAL_PBS_NB; i++) begin
      w_wr_hit[i]  = bus.ks_boram_wr_en && (bus.ks_boram_wr_pid == pid_t'(i));
      w_clr[i]     = w_accept && (bus.boram_rd_pid == pid_t'(i));
      w_corr_tk[i] = bus.seq_boram_corr_wr_en && (bus.seq_boram_corr_wr_pid == pid_t'(i))
                  && (w_clr[i] || (r_cnt[i] != cnt_t'(LWE_K)));
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      for (int i = 0; i < TOTAL_PBS_NB; i++) begin
        r_vld[i] <= 1'b0;
        r_par[i] <= 1'b0;
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else if (bus.reset_cache) begin
      for (int i = 0; i < TOTAL_PBS_NB; i++) begin
        r_vld[i] <= 1'b0;
        r_par[i] <= 1'b0;
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < TOTAL_PBS_NB; i++) begin
        if (w_wr_hit[i]) begin
          r_vld[i] <= 1'b1;
          r_par[i] <= bus.ks_boram_wr_parity;
        end else if (w_clr[i]) begin
          r_vld[i] <= 1'b0;
        end
        if (w_corr_tk[i]) begin
          r_acc[i] <= (w_clr[i] ? seq_corr_t'(0) : r_acc[i]) + bus.seq_boram_corr_wr_data;
          r_cnt[i] <= (w_clr[i] ? cnt_t'(0) : r_cnt[i]) + cnt_t'(1);
        end else if (w_clr[i]) begin
          r_acc[i] <= '0;
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Body data needs no reset: it is only observed through the valid flag.
  always_ff @(posedge clk) begin
    for (int i = 0; i < TOTAL_PBS_NB; i++) begin
      if (w_wr_hit[i]) begin
        r_body[i] <= bus.ks_boram_wr_data;
      end
    end
  end

  pep_mmacc_body_modsw u_modsw (
    .i_body (r_body[bus.boram_rd_pid]),
    .i_acc  (r_acc[bus.boram_rd_pid]),
    .o_data (w_modsw)
  );

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
    end else if (bus.reset_cache) begin
      r_out_vld  <= 1'b0;
    end else if (w_accept) begin
      r_out_vld  <= 1'b1;
      r_out_data <= w_modsw;
    end else if (bus.boram_sxt_data_rdy) begin
      r_out_vld  <= 1'b0;
    end
  end

`ifdef BORAM_ASSERT_EN
  a_corr_overflow: assert property (@(posedge clk) disable iff (!a_rst_n || bus.reset_cache)
    bus.seq_boram_corr_wr_en |-> (r_cnt[bus.seq_boram_corr_wr_pid] != cnt_t'(LWE_K))
      || w_clr[bus.seq_boram_corr_wr_pid])
    else $error("correction write on a complete slot");

  a_pid_range: assert property (@(posedge clk) disable iff (!a_rst_n)
    bus.boram_rd_vld |-> ({1'b0, bus.boram_rd_pid} < (PID_W+1)'(TOTAL_PBS_NB)))
    else $error("read pid out of range");

  a_out_stable: assert property (@(posedge clk) disable iff (!a_rst_n || bus.reset_cache)
    (r_out_vld && !bus.boram_sxt_data_rdy) |=> $stable(r_out_data))
    else $error("output data changed under backpressure");
`endif
endmodule
`default_nettype wire

// File: tb/tb_pep_mmacc_body_buf.sv
// tb_pep_mmacc_body_buf: scoreboard bench for the body buffer read/correction/mod-switch path.
`default_nettype none
module tb_pep_mmacc_body_buf;
  import pep_mmacc_body_buf_pkg::*;

  logic clk = 1'b0;
  logic a_rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  logic [LWE_COEF_W-1:0] sb[$];

  pep_mmacc_body_buf_if bif ();

  pep_mmacc_body_buf dut (
    .clk     (clk),
    .a_rst_n (a_rst_n),
    .bus     (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: x = body*2^F - acc*mean, rounded to nearest at 2^(MOD_KSK_W-LWE_COEF_W+F).
  function automatic logic [LWE_COEF_W-1:0] model(input longint body, input longint acc);
    longint x, t, q, div;
    div = longint'(1) << RND_LSB;
    x = body * (longint'(1) << KS_KEY_MEAN_FRAC_W) - acc * KS_KEY_MEAN_FP;
    t = x + div / 2;
    q = (t >= 0) ? t / div : -((-t + div - 1) / div);
    return q[LWE_COEF_W-1:0];
  endfunction

  always @(negedge clk) begin
    if (a_rst_n && bif.boram_sxt_data_vld && bif.boram_sxt_data_rdy) begin
      if (sb.size() == 0) chk("sb_extra", 32'd1, 32'd0);
      else chk("sxt_data", 32'(bif.boram_sxt_data), 32'(sb.pop_front()));
    end
  end

  task automatic wr_body(input int pid, input int data, input bit par);
    bif.ks_boram_wr_en = 1'b1;
    bif.ks_boram_wr_pid = pid_t'(pid);
    bif.ks_boram_wr_data = ks_coeff_t'(data);
    bif.ks_boram_wr_parity = par;
    @(posedge clk); #1;
    bif.ks_boram_wr_en = 1'b0;
  endtask

  // n correction writes; the first four carry total/4 each, the rest zero.
  task automatic corr_n(input int pid, input int n, input int total);
    for (int k = 0; k < n; k++) begin
      bif.seq_boram_corr_wr_en = 1'b1;
      bif.seq_boram_corr_wr_pid = pid_t'(pid);
      bif.seq_boram_corr_wr_data = (k < 4) ? seq_corr_t'(total / 4) : seq_corr_t'(0);
      @(posedge clk); #1;
    end
    bif.seq_boram_corr_wr_en = 1'b0;
  endtask

  task automatic rd(input int pid, input bit par, input logic [LWE_COEF_W-1:0] exp);
    bit done = 0;
    bif.boram_rd_vld = 1'b1;
    bif.boram_rd_pid = pid_t'(pid);
    bif.boram_rd_parity = par;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (bif.boram_rd_rdy) begin
        sb.push_back(exp);
        done = 1;
      end
      @(posedge clk); #1;
    end
    bif.boram_rd_vld = 1'b0;
    if (!done) chk("rd_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_stall(input string tag, input int pid, input bit par, input int cycles);
    bif.boram_rd_vld = 1'b1;
    bif.boram_rd_pid = pid_t'(pid);
    bif.boram_rd_parity = par;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      chk(tag, 32'(bif.boram_rd_rdy), 32'd0);
      @(posedge clk); #1;
    end
    bif.boram_rd_vld = 1'b0;
  endtask

  initial begin
    logic [LWE_COEF_W-1:0] held;
    bif.reset_cache = 1'b0;
    bif.ks_boram_wr_en = 1'b0;
    bif.ks_boram_wr_data = '0;
    bif.ks_boram_wr_pid = '0;
    bif.ks_boram_wr_parity = 1'b0;
    bif.seq_boram_corr_wr_en = 1'b0;
    bif.seq_boram_corr_wr_data = '0;
    bif.seq_boram_corr_wr_pid = '0;
    bif.boram_rd_pid = '0;
    bif.boram_rd_parity = 1'b0;
    bif.boram_rd_vld = 1'b1;
    bif.boram_sxt_data_rdy = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_rdy", 32'(bif.boram_rd_rdy), 32'd0);
    chk("rst_out_vld", 32'(bif.boram_sxt_data_vld), 32'd0);
    bif.boram_rd_vld = 1'b0;
    @(posedge clk); #1;
    a_rst_n = 1'b1;
    @(posedge clk); #1;

    // basic read, one-cycle latency, then slot is consumed
    wr_body(3, 'h1FF, 0);
    corr_n(3, LWE_K, 0);
    rd(3, 0, model('h1FF, 0));
    @(negedge clk);
    chk("latency_vld", 32'(bif.boram_sxt_data_vld), 32'd1);
    @(posedge clk); #1;
    expect_stall("consumed", 3, 0, 2);

    // parity mismatch, then rewrite with matching parity
    wr_body(5, 'h1FF, 1);
    corr_n(5, LWE_K, 0);
    expect_stall("parity", 5, 0, 3);
    wr_body(5, 'h1FF, 0);
    rd(5, 0, model('h1FF, 0));

    // correction with key mean 0.5; incomplete corrections stall
    wr_body(6, 'h800, 0);
    corr_n(6, LWE_K - 1, 1024);
    expect_stall("incomplete", 6, 0, 2);
    corr_n(6, 1, 0);
    rd(6, 0, model('h800, 1024));

    // negative wrap and negative accumulator
    wr_body(8, 0, 1);
    corr_n(8, LWE_K, 1024);
    rd(8, 1, model(0, 1024));
    wr_body(9, 'h1000, 0);
    corr_n(9, LWE_K, -2048);
    rd(9, 0, model('h1000, -2048));

    // reset_cache clears slots
    wr_body(7, 'h1FF, 0);
    corr_n(7, LWE_K, 0);
    bif.reset_cache = 1'b1;
    @(posedge clk); #1;
    bif.reset_cache = 1'b0;
    expect_stall("rc_clear", 7, 0, 3);
    wr_body(7, 'h1FF, 0);
    expect_stall("rc_nocorr", 7, 0, 2);
    corr_n(7, LWE_K, 0);
    rd(7, 0, model('h1FF, 0));

    // same-cycle body rewrite and correction on the accepted pid
    wr_body(12, 'h1FF, 0);
    corr_n(12, LWE_K, 0);
    bif.boram_rd_vld = 1'b1;
    bif.boram_rd_pid = pid_t'(12);
    bif.boram_rd_parity = 1'b0;
    bif.ks_boram_wr_en = 1'b1;
    bif.ks_boram_wr_pid = pid_t'(12);
    bif.ks_boram_wr_data = ks_coeff_t'('h800);
    bif.ks_boram_wr_parity = 1'b0;
    bif.seq_boram_corr_wr_en = 1'b1;
    bif.seq_boram_corr_wr_pid = pid_t'(12);
    bif.seq_boram_corr_wr_data = seq_corr_t'(1024);
    @(negedge clk);
    chk("coll_rd_rdy", 32'(bif.boram_rd_rdy), 32'd1);
    if (bif.boram_rd_rdy) sb.push_back(model('h1FF, 0));
    @(posedge clk); #1;
    bif.boram_rd_vld = 1'b0;
    bif.ks_boram_wr_en = 1'b0;
    bif.seq_boram_corr_wr_en = 1'b0;
    expect_stall("coll_cnt1", 12, 0, 1);
    corr_n(12, LWE_K - 2, 0);
    expect_stall("coll_cnt", 12, 0, 1);
    corr_n(12, 1, 0);
    rd(12, 0, model('h800, 1024));

    // backpressure: held data stable, second read stalled, order preserved
    wr_body(10, 'h800, 0);
    corr_n(10, LWE_K, 1024);
    wr_body(11, 'h1FF, 1);
    corr_n(11, LWE_K, 0);
    bif.boram_sxt_data_rdy = 1'b0;
    rd(10, 0, model('h800, 1024));
    held = model('h800, 1024);
    bif.boram_rd_vld = 1'b1;
    bif.boram_rd_pid = pid_t'(11);
    bif.boram_rd_parity = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_rd_rdy", 32'(bif.boram_rd_rdy), 32'd0);
      chk("bp_vld", 32'(bif.boram_sxt_data_vld), 32'd1);
      chk("bp_stable", 32'(bif.boram_sxt_data), 32'(held));
      @(posedge clk); #1;
    end
    bif.boram_sxt_data_rdy = 1'b1;
    rd(11, 1, model('h1FF, 0));

    for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
